fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one synchronous FIFO write port among N_REQ producers.
- Drives the FIFO's w_en/data_in and honours its full flag.
- Grants bounded bursts so that no producer starves.
- Sits between producer blocks and the synchronous_fifo interface (tb-side signals w_en, data_in, full).

---
 rtl/fifo_arb_pkg.sv | 49 ++++
 rtl/fifo_wr_arbiter_rr_picker.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types, default parameters and the round-robin search function used by
// the FIFO write arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BURST)
//   rr_pick()   : wrap-around first-set-bit search starting at a pointer
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 2;
    localparam int MAX_BURST_DEF = 4;

    // Upper bound on requesters; the search function works on a vector this
    // wide and callers zero-extend into it.
    localparam int MAX_N = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Returns the first set bit of req[n-1:0] found by searching upward from
    // ptr and wrapping back to 0 after n-1. ptr must be < n.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                         input int unsigned       ptr,
                                         input int unsigned       n);
        rr_pick_t    r;
        logic [2:0]  cand;
        int unsigned sum;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                sum  = ptr + k;
                // explicit modulo-n wrap so non power-of-2 n behaves
                cand = (sum >= n) ? 3'(sum - n) : 3'(sum);
                if (!r.valid && req[cand]) begin
                    r.valid = 1'b1;
                    r.idx   = cand;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational wrap-around priority search.
//   req   : candidate request vector
//   ptr   : index to start searching from (highest priority)
//   valid : at least one req bit set
//   idx   : winning index
// -----------------------------------------------------------------------------
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_N'(req), 32'(ptr), N_REQ);
        valid = pick.valid;
        idx   = PTR_W'(pick.idx);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one synchronous FIFO write port among N_REQ
// producers. A grant is a burst of at most MAX_BURST accepted writes; the
// burst ends early if the owner drops req. FIFO full stalls a burst but never
// ends it. Arbitration in IDLE costs one bubble cycle.
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   req           : per-requester level request (held until acked)
//   data          : packed write data, requester i at [i*DATA_W +: DATA_W]
//   prio          : (FIFO_ARB_PRIO_EN only) priority subset for IDLE search
//   ack           : one-hot, requester's word written this cycle
//   fifo_full     : FIFO full flag
//   fifo_w_en     : FIFO write enable
//   fifo_data_in  : FIFO write data (owner's data in BURST, 0 in IDLE)
//   busy          : in BURST state
//   owner         : current / last burst owner
//
// Optional feature macro: FIFO_ARB_PRIO_EN
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int PTR_W     = $clog2(N_REQ),
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
`ifdef FIFO_ARB_PRIO_EN
    input  logic [N_REQ-1:0]          prio,
`endif
    output logic [N_REQ-1:0]          ack,
    input  logic                      fifo_full,
    output logic                      fifo_w_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      busy,
    output logic [PTR_W-1:0]          owner
);

    arb_state_t        state_reg;
    logic [PTR_W-1:0]  owner_reg;
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;

    logic [N_REQ-1:0]  search_req;
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic              in_burst;
    logic              owner_req;
    logic              accept;
    logic              last_beat;
    logic [PTR_W-1:0]  owner_inc;
    logic [DATA_W-1:0] data_words [N_REQ];

    // Unpack the flat data bus so the owner can select its word directly.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign data_words[gi] = data[gi*DATA_W +: DATA_W];
    end

`ifdef FIFO_ARB_PRIO_EN
    // Prioritised requesters, when any are present, hide the rest.
    assign search_req = (|(req & prio)) ? (req & prio) : req;
`else
    assign search_req = req;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (search_req),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign in_burst  = (state_reg == BURST);
    assign owner_req = req[owner_reg];
    // Gate with rst_n so a word in flight while reset is asserted never lands.
    assign accept    = in_burst & owner_req & ~fifo_full & rst_n;
    assign last_beat = (beat_cnt_reg == CNT_W'(MAX_BURST - 1));
    assign owner_inc = (owner_reg == PTR_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
        assign ack[gi] = accept & (owner_reg == PTR_W'(gi));
    end

    assign fifo_w_en    = accept;
    assign fifo_data_in = in_burst ? data_words[owner_reg] : '0;
    assign busy         = in_burst;
    assign owner        = owner_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        owner_reg    <= pick_idx;
                        beat_cnt_reg <= '0;
                        state_reg    <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_req) begin
                        // owner released early: forfeit remaining beats
                        state_reg  <= IDLE;
                        rr_ptr_reg <= owner_inc;
                    end else if (!fifo_full) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        if (last_beat) begin
                            state_reg  <= IDLE;
                            rr_ptr_reg <= owner_inc;
                        end
                    end
                    // full with req held: stall, hold everything
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Cycle-by-cycle vector table for fifo_wr_arbiter (N_REQ=4, DATA_W=2,
// MAX_BURST=4). Each record gives the inputs for one clock cycle and the
// outputs expected during that cycle. Inputs change just after a rising edge,
// outputs are sampled on the falling edge.
// Data words: d0=01, d1=10, d2=11, d3=00 (data bus 8'h39).
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] prio;
        logic       full;
        logic [3:0] ack;
        logic       w_en;
        logic [1:0] dout;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] data;
    logic [3:0] prio;
    logic [3:0] ack;
    logic       fifo_full;
    logic       fifo_w_en;
    logic [1:0] fifo_data_in;
    logic       busy;
    logic [1:0] owner;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (4),
        .DATA_W    (2),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .data         (data),
`ifdef FIFO_ARB_PRIO_EN
        .prio         (prio),
`endif
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .busy         (busy),
        .owner        (owner)
    );

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] pr,
                       input logic f, input logic [3:0] a, input logic w,
                       input logic [1:0] d, input logic b, input logic [1:0] o);
        vec_t v;
        v.rst_n = r; v.req = rq; v.prio = pr; v.full = f;
        v.ack = a; v.w_en = w; v.dout = d; v.busy = b; v.owner = o;
        vecs.push_back(v);
    endtask

    // n consecutive write beats for requester o with word d
    task automatic add_beats(input int n, input logic [3:0] rq, input logic [1:0] o,
                             input logic [1:0] d);
        for (int k = 0; k < n; k++)
            add(1, rq, 4'b0000, 0, 4'b0001 << o, 1, d, 1, o);
    endtask

    task automatic chk(input int i, input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL vec %0d %s: got %b, expected %b", i, name, act, exp);
    endtask

    initial begin
        // ---- reset with all requesting ----
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd0);
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd0);
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd0);   // first cycle after release
        // ---- full fairness 0,1,2,3,0 ----
        add_beats(4, 4'b1111, 2'd0, 2'b01);
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd0);
        add_beats(4, 4'b1111, 2'd1, 2'b10);
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd1);
        add_beats(4, 4'b1111, 2'd2, 2'b11);
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd2);
        add_beats(4, 4'b1111, 2'd3, 2'b00);
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd3);
        add_beats(1, 4'b1111, 2'd0, 2'b01);
        // ---- reset mid-burst: word in flight is not written ----
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 2'b01, 1, 2'd0);
        // ---- single requester 2 ----
        add(1, 4'b0100, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd0);
        add_beats(4, 4'b0100, 2'd2, 2'b11);
        add(1, 4'b0100, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd2);
        add_beats(1, 4'b0100, 2'd2, 2'b11);
        // owner 2 drops, requester 1 takes over
        add(1, 4'b0010, 0, 0, 4'b0000, 0, 2'b11, 1, 2'd2);
        add(1, 4'b0010, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd2);
        // ---- backpressure on owner 1 after 2 beats ----
        add_beats(2, 4'b0010, 2'd1, 2'b10);
        add(1, 4'b0010, 0, 1, 4'b0000, 0, 2'b10, 1, 2'd1);
        add(1, 4'b0010, 0, 1, 4'b0000, 0, 2'b10, 1, 2'd1);
        add(1, 4'b0010, 0, 1, 4'b0000, 0, 2'b10, 1, 2'd1);
        add_beats(2, 4'b0010, 2'd1, 2'b10);
        add(1, 4'b1000, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd1);   // IDLE, picks 3
        // ---- early release by owner 3 after 1 beat ----
        add_beats(1, 4'b1001, 2'd3, 2'b00);
        add(1, 4'b0011, 0, 0, 4'b0000, 0, 2'b00, 1, 2'd3);
        add(1, 4'b0011, 0, 0, 4'b0000, 0, 2'b00, 0, 2'd3);
        add_beats(1, 4'b0011, 2'd0, 2'b01);
`ifdef FIFO_ARB_PRIO_EN
        // ---- priority subset in IDLE ----
        add(0, 4'b1011, 4'b1000, 0, 4'b0000, 0, 2'b01, 1, 2'd0);
        add(1, 4'b1011, 4'b1000, 0, 4'b0000, 0, 2'b00, 0, 2'd0);
        add(1, 4'b1011, 4'b1000, 0, 4'b1000, 1, 2'b00, 1, 2'd3);
        add(0, 4'b1011, 4'b0000, 0, 4'b0000, 0, 2'b00, 1, 2'd3);
        add(1, 4'b1011, 4'b0000, 0, 4'b0000, 0, 2'b00, 0, 2'd0);
        add(1, 4'b1011, 4'b0000, 0, 4'b0001, 1, 2'b01, 1, 2'd0);
`endif

        data = 8'h39;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = vecs[i].rst_n;
            req       = vecs[i].req;
            prio      = vecs[i].prio;
            fifo_full = vecs[i].full;
            @(negedge clk);
            chk(i, "ack",   ack,                 vecs[i].ack);
            chk(i, "w_en",  {3'b000, fifo_w_en}, {3'b000, vecs[i].w_en});
            chk(i, "data",  {2'b00, fifo_data_in}, {2'b00, vecs[i].dout});
            chk(i, "busy",  {3'b000, busy},      {3'b000, vecs[i].busy});
            chk(i, "owner", {2'b00, owner},      {2'b00, vecs[i].owner});
            $display("vec %0d: rst_n=%b req=%b full=%b -> ack=%b w_en=%b data=%b busy=%b owner=%0d",
                     i, rst_n, req, fifo_full, ack, fifo_w_en, fifo_data_in, busy, owner);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
